// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 multiplexer built as a binary 2:1 reduction tree, one register stage per select bit,
// with valid/ready flow control. Define MUX_TREE_PIPE_SEL_CHECK_EN to add the sticky sel_err output.
module mux_tree_pipe #(
  parameter int WIDTH      = 8,
  parameter int NUM_INPUTS = 8,
  localparam int SEL_W     = $clog2(NUM_INPUTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH*NUM_INPUTS-1:0] ins,
  input  logic [SEL_W-1:0]            sel,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [WIDTH-1:0]            out,
  output logic                        out_valid,
  input  logic                        out_ready
`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
  ,
  output logic                        sel_err
`endif
);

  localparam int LEVELS = SEL_W;

  logic advance_s;

  // The whole pipeline moves as one; a stalled full output freezes every stage.
  assign advance_s = out_ready | ~out_valid;
  assign in_ready  = advance_s;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_stage
    localparam int IN_CNT   = (NUM_INPUTS + (1 << (k - 1)) - 1) >> (k - 1);
    localparam int OUT_CNT  = (NUM_INPUTS + (1 << k) - 1) >> k;
    localparam int SEL_IN_W = SEL_W - k + 1;

    logic [IN_CNT*WIDTH-1:0]  din_s;
    logic [SEL_IN_W-1:0]      sin_s;
    logic                     vin_s;
    wire  [OUT_CNT*WIDTH-1:0] nxt_s;
    logic [OUT_CNT*WIDTH-1:0] data_r;
    logic                     valid_r;

    if (k == 1) begin : g_src
      assign din_s = ins;
      assign sin_s = sel;
      assign vin_s = in_valid;
    end else begin : g_src
      assign din_s = g_stage[k-1].data_r;
      assign sin_s = g_stage[k-1].g_sel.sel_r;
      assign vin_s = g_stage[k-1].valid_r;
    end

    // A missing odd partner acts as a zero lane, which also makes out-of-range selects yield zero.
    for (genvar j = 0; j < OUT_CNT; j++) begin : g_pair
      if (2 * j + 1 < IN_CNT) begin : g_two
        assign nxt_s[j*WIDTH +: WIDTH] = sin_s[0] ? din_s[(2*j+1)*WIDTH +: WIDTH]
                                                  : din_s[(2*j)*WIDTH +: WIDTH];
      end else begin : g_one
        assign nxt_s[j*WIDTH +: WIDTH] = sin_s[0] ? {WIDTH{1'b0}}
                                                  : din_s[(2*j)*WIDTH +: WIDTH];
      end
    end

    // Stage data/valid register; bubbles carry zero data so the output is zero when not valid.
    always_ff @(posedge clk) begin
      if (rst) begin
        data_r  <= {(OUT_CNT*WIDTH){1'b0}};
        valid_r <= 1'b0;
      end else if (advance_s) begin
        data_r  <= vin_s ? nxt_s : {(OUT_CNT*WIDTH){1'b0}};
        valid_r <= vin_s;
      end else begin
        data_r  <= data_r;
        valid_r <= valid_r;
      end
    end

    if (k < LEVELS) begin : g_sel
      logic [SEL_W-k-1:0] sel_r;

      // Carry the select bits still needed by later stages.
      always_ff @(posedge clk) begin
        if (rst) begin
          sel_r <= {(SEL_W-k){1'b0}};
        end else if (advance_s) begin
          sel_r <= sin_s[SEL_IN_W-1:1];
        end else begin
          sel_r <= sel_r;
        end
      end
    end
  end

  assign out       = g_stage[LEVELS].data_r;
  assign out_valid = g_stage[LEVELS].valid_r;

`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W + 1)'(NUM_INPUTS);

  logic bad_accept_s;
  logic sel_err_r;

  assign bad_accept_s = in_valid & advance_s & ({1'b0, sel} >= NUM_IN_W);

  // Sticky out-of-range flag; only reset clears it and reset wins over a same-edge bad accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err_r <= 1'b0;
    end else if (bad_accept_s) begin
      sel_err_r <= 1'b1;
    end else begin
      sel_err_r <= sel_err_r;
    end
  end

  assign sel_err = sel_err_r;
`endif

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Self-checking bench for mux_tree_pipe: an 8-lane and a 5-lane instance checked against
// a transaction-level model (result value computed at acceptance, delayed by the pipeline depth).
module tb_mux_tree_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] ins8;
  logic [2:0]  sel8;
  logic        iv8, ir8, ov8, or8;
  logic [7:0]  out8;
  logic [39:0] ins5;
  logic [2:0]  sel5;
  logic        iv5, ir5, ov5, or5;
  logic [7:0]  out5;
`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
  logic        err8, err5;
`endif

  int checks = 0;
  int fails  = 0;

  bit         m8_v [1:3];
  logic [7:0] m8_d [1:3];
  bit         m5_v [1:3];
  logic [7:0] m5_d [1:3];
  bit         m8_err, m5_err;

  mux_tree_pipe #(.WIDTH(8), .NUM_INPUTS(8)) dut8 (
    .clk(clk), .rst(rst), .ins(ins8), .sel(sel8), .in_valid(iv8), .in_ready(ir8),
    .out(out8), .out_valid(ov8), .out_ready(or8)
`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
    , .sel_err(err8)
`endif
  );

  mux_tree_pipe #(.WIDTH(8), .NUM_INPUTS(5)) dut5 (
    .clk(clk), .rst(rst), .ins(ins5), .sel(sel5), .in_valid(iv5), .in_ready(ir5),
    .out(out5), .out_valid(ov5), .out_ready(or5)
`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
    , .sel_err(err5)
`endif
  );

  function automatic logic [7:0] pick(input logic [63:0] v, input int s, input int n);
    if (s < n) return v[s*8 +: 8];
    return 8'h00;
  endfunction

  // One clock edge: the model accepts/advances exactly like a depth-3 transaction queue.
  task automatic tick();
    bit a8, a5;
    logic [7:0] e8, e5;
    a8 = or8 || !m8_v[3];
    a5 = or5 || !m5_v[3];
    e8 = iv8 ? pick(ins8, int'(sel8), 8) : 8'h00;
    e5 = iv5 ? pick({24'h0, ins5}, int'(sel5), 5) : 8'h00;
    @(posedge clk);
    if (rst) begin
      for (int i = 1; i <= 3; i++) begin
        m8_v[i] = 1'b0; m8_d[i] = 8'h00; m5_v[i] = 1'b0; m5_d[i] = 8'h00;
      end
      m8_err = 1'b0; m5_err = 1'b0;
    end else begin
      if (a8) begin
        m8_v[3] = m8_v[2]; m8_d[3] = m8_d[2];
        m8_v[2] = m8_v[1]; m8_d[2] = m8_d[1];
        m8_v[1] = iv8;     m8_d[1] = e8;
      end
      if (a5) begin
        m5_v[3] = m5_v[2]; m5_d[3] = m5_d[2];
        m5_v[2] = m5_v[1]; m5_d[2] = m5_d[1];
        m5_v[1] = iv5;     m5_d[1] = e5;
        if (iv5 && sel5 >= 3'd5) m5_err = 1'b1;
      end
    end
    #1;
  endtask

  task automatic set_lanes();
    for (int i = 0; i < 8; i++) ins8[i*8 +: 8] = 8'(8'h10 + i);
    for (int i = 0; i < 5; i++) ins5[i*8 +: 8] = 8'(8'h10 + i);
  endtask

  task automatic test_reset();
    rst = 1'b1; iv8 = 1'b0; iv5 = 1'b0; or8 = 1'b0; or5 = 1'b0;
    sel8 = 3'd0; sel5 = 3'd0; ins8 = 64'h0; ins5 = 40'h0;
    tick(); tick();
    checks++; if (ov8 !== 1'b0) begin fails++; $display("FAIL reset_ov8: got %b want 0", ov8); end
    checks++; if (out8 !== 8'h00) begin fails++; $display("FAIL reset_out8: got %h want 00", out8); end
    checks++; if (ov5 !== 1'b0) begin fails++; $display("FAIL reset_ov5: got %b want 0", ov5); end
    rst = 1'b0;
    #1;
    checks++; if (ir8 !== 1'b1) begin fails++; $display("FAIL reset_ir8: got %b want 1", ir8); end
    tick();
    checks++; if (ir5 !== 1'b1) begin fails++; $display("FAIL post_reset_ir5: got %b want 1", ir5); end
`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
    checks++; if (err5 !== 1'b0) begin fails++; $display("FAIL reset_err5: got %b want 0", err5); end
`endif
  endtask

  task automatic test_single();
    int lat;
    set_lanes(); or8 = 1'b1; sel8 = 3'd5; iv8 = 1'b1;
    tick();
    iv8 = 1'b0; lat = 1;
    while (!ov8 && lat < 10) begin tick(); lat++; end
    checks++; if (lat !== 3) begin fails++; $display("FAIL single_latency: got %0d want 3", lat); end
    checks++; if (out8 !== 8'h15) begin fails++; $display("FAIL single_out: got %h want 15", out8); end
    tick();
    checks++; if (ov8 !== 1'b0 || out8 !== 8'h00) begin
      fails++; $display("FAIL single_idle_out: got v=%b d=%h want v=0 d=00", ov8, out8);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got[$];
    int idx[$];
    set_lanes(); or8 = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (c < 8) begin sel8 = 3'(c); iv8 = 1'b1; end else iv8 = 1'b0;
      tick();
      checks++; if (ov8 !== m8_v[3] || out8 !== m8_d[3]) begin
        fails++; $display("FAIL b2b_cycle%0d: got v=%b d=%h want v=%b d=%h", c, ov8, out8, m8_v[3], m8_d[3]);
      end
      if (ov8) begin got.push_back(out8); idx.push_back(c); end
    end
    checks++; if (got.size() !== 8) begin fails++; $display("FAIL b2b_count: got %0d want 8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      checks++; if (got[i] !== 8'(8'h10 + i) || idx[i] !== 2 + i) begin
        fails++; $display("FAIL b2b_item%0d: got %h at %0d want %h at %0d", i, got[i], idx[i], 8'(8'h10 + i), 2 + i);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] got[$];
    int sent, stall_left;
    bit started, in_stall, deliv, acc;
    logic [7:0] val;
    set_lanes(); sent = 0; stall_left = 0; started = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (sent < 4) begin iv8 = 1'b1; sel8 = 3'(sent); end else iv8 = 1'b0;
      in_stall = (stall_left > 0);
      or8 = !in_stall;
      #1;
      if (in_stall) begin
        checks++; if (ir8 !== 1'b0) begin fails++; $display("FAIL stall_in_ready: got %b want 0", ir8); end
      end
      acc = iv8 && ir8; deliv = ov8 && or8; val = out8;
      tick();
      if (acc) sent++;
      if (deliv) got.push_back(val);
      if (in_stall) begin
        stall_left--;
        checks++; if (ov8 !== 1'b1 || out8 !== 8'h10) begin
          fails++; $display("FAIL stall_hold: got v=%b d=%h want v=1 d=10", ov8, out8);
        end
      end
      if (!started && ov8) begin started = 1'b1; stall_left = 5; end
    end
    or8 = 1'b1;
    checks++; if (got.size() !== 4) begin fails++; $display("FAIL stall_count: got %0d want 4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      checks++; if (got[i] !== 8'(8'h10 + i)) begin
        fails++; $display("FAIL stall_item%0d: got %h want %h", i, got[i], 8'(8'h10 + i));
      end
    end
  endtask

  task automatic test_reset_midflight();
    set_lanes(); or8 = 1'b1;
    sel8 = 3'd2; iv8 = 1'b1; tick();
    sel8 = 3'd3; tick();
    iv8 = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (ov8 !== 1'b0 || out8 !== 8'h00) begin
      fails++; $display("FAIL midrst_now: got v=%b d=%h want v=0 d=00", ov8, out8);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (ov8 !== 1'b0 || out8 !== 8'h00) begin
        fails++; $display("FAIL midrst_c%0d: got v=%b d=%h want v=0 d=00", c, ov8, out8);
      end
    end
  endtask

  task automatic test_bubbles();
    logic [7:0] exp_d [0:2];
    bit exp_v [0:2];
    exp_v[0] = 1'b1; exp_d[0] = 8'h11;
    exp_v[1] = 1'b0; exp_d[1] = 8'h00;
    exp_v[2] = 1'b1; exp_d[2] = 8'h12;
    set_lanes(); or8 = 1'b1;
    iv8 = 1'b1; sel8 = 3'd1; tick();
    iv8 = 1'b0; sel8 = 3'($urandom_range(0, 7)); tick();
    iv8 = 1'b1; sel8 = 3'd2; tick();
    iv8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      checks++; if (ov8 !== exp_v[i] || out8 !== exp_d[i]) begin
        fails++; $display("FAIL bubble_%0d: got v=%b d=%h want v=%b d=%h", i, ov8, out8, exp_v[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_odd_lanes();
    set_lanes(); or5 = 1'b1;
    iv5 = 1'b1; sel5 = 3'd4; tick();
    iv5 = 1'b0; tick(); tick();
    checks++; if (ov5 !== 1'b1 || out5 !== 8'h14) begin
      fails++; $display("FAIL n5_sel4: got v=%b d=%h want v=1 d=14", ov5, out5);
    end
`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
    checks++; if (err5 !== 1'b0) begin fails++; $display("FAIL n5_err_clean: got %b want 0", err5); end
`endif
    iv5 = 1'b1; sel5 = 3'd6; tick();
    iv5 = 1'b0;
`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
    checks++; if (err5 !== 1'b1) begin fails++; $display("FAIL n5_err_set: got %b want 1", err5); end
`endif
    tick(); tick();
    checks++; if (ov5 !== 1'b1 || out5 !== 8'h00) begin
      fails++; $display("FAIL n5_sel6: got v=%b d=%h want v=1 d=00", ov5, out5);
    end
    rst = 1'b1; iv5 = 1'b1; sel5 = 3'd7; tick();
    rst = 1'b0; iv5 = 1'b0;
`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
    checks++; if (err5 !== 1'b0) begin fails++; $display("FAIL n5_err_rst_wins: got %b want 0", err5); end
`endif
    checks++; if (ov5 !== 1'b0) begin fails++; $display("FAIL n5_rst_ov: got %b want 0", ov5); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst  = ($urandom_range(0, 59) == 0);
      ins8 = {$urandom(), $urandom()};
      sel8 = 3'($urandom_range(0, 7));
      iv8  = ($urandom_range(0, 3) != 0);
      or8  = ($urandom_range(0, 9) < 7);
      ins5 = 40'({$urandom(), $urandom()});
      sel5 = 3'($urandom_range(0, 7));
      iv5  = ($urandom_range(0, 3) != 0);
      or5  = ($urandom_range(0, 9) < 7);
      #1;
      checks++; if (ir8 !== (or8 || !m8_v[3]) || ir5 !== (or5 || !m5_v[3])) begin
        fails++; $display("FAIL rnd_ready_c%0d: got %b/%b want %b/%b", c, ir8, ir5, or8 || !m8_v[3], or5 || !m5_v[3]);
      end
      tick();
      checks++; if (ov8 !== m8_v[3] || out8 !== m8_d[3]) begin
        fails++; $display("FAIL rnd8_c%0d: got v=%b d=%h want v=%b d=%h", c, ov8, out8, m8_v[3], m8_d[3]);
      end
      checks++; if (ov5 !== m5_v[3] || out5 !== m5_d[3]) begin
        fails++; $display("FAIL rnd5_c%0d: got v=%b d=%h want v=%b d=%h", c, ov5, out5, m5_v[3], m5_d[3]);
      end
`ifdef MUX_TREE_PIPE_SEL_CHECK_EN
      checks++; if (err5 !== m5_err || err8 !== m8_err) begin
        fails++; $display("FAIL rnd_err_c%0d: got %b/%b want %b/%b", c, err8, err5, m8_err, m5_err);
      end
`endif
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_bubbles();
    test_odd_lanes();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
